scores: RTL and testbench

- Score keeper for a two-player game such as pong.
- Counts points awarded to player 1 and player 2 on separate request lines.
- Declares the match over when either score reaches a parameterised target, and reports which player won.
- Sits between the game/ball logic (source of point pulses) and the display logic (consumer of scores and status).

---
 rtl/scores_pkg.sv | 29 ++
 rtl/scores_edge_det.sv | 59 +++++
 rtl/scores.sv | 128 ++++++++++++
 tb/tb_scores.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scores_pkg.sv
// -----------------------------------------------------------------------------
// scores_pkg
// Shared constants and types for the two-player score keeper.
//   SCORE_W        : width of each score (3 bits, scores 0..7)
//   WIN_SCORE_DEF  : default score that ends the match
//   state_t        : match FSM states (PLAY, OVER)
//   P1_WIN/P2_WIN  : encoding of the winner output
// Optional build macro used by this slice: SCORES_INPUT_SYNC_EN
// -----------------------------------------------------------------------------
package scores_pkg;

  localparam int SCORE_W       = 3;
  localparam int WIN_SCORE_DEF = 5;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam logic P1_WIN = 1'b0;
  localparam logic P2_WIN = 1'b1;

  // Add one to a score; callers guarantee the result never exceeds the
  // win target, so no wrap handling is needed here.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return s + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/scores_edge_det.sv
// -----------------------------------------------------------------------------
// scores_edge_det
// Turns a level "point" request into a one-cycle rise pulse. The pulse is
// combinational from the sampled level and the history register, so the
// consumer can act on the very edge that first sees the level high.
//
// Build option SCORES_INPUT_SYNC_EN: when defined, the raw input passes
// through a two-flop synchronizer first (adds two clocks of latency).
//
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   point_i  : level request from the game logic
//   rise_o   : high for one cycle when the (synchronized) level rises
// -----------------------------------------------------------------------------
module scores_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic point_i,
  output logic rise_o
);

  logic level_s;
  logic prev_q;

`ifdef SCORES_INPUT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for an input from another clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= point_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = point_i;
`endif

  // History register: level as seen on the previous clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  // A held-high line yields a single pulse; it must drop for a clock to
  // produce another.
  assign rise_o = level_s & ~prev_q;

endmodule

// File: rtl/scores.sv
// -----------------------------------------------------------------------------
// scores
// Score keeper for a two-player game. Counts rising edges on point1/point2,
// ends the match when either score reaches WIN_SCORE and reports the winner.
// All outputs come straight from registers.
//
// Build option SCORES_INPUT_SYNC_EN: synchronizes point1/point2 before edge
// detection (score updates two clocks later than the unsynchronized build).
//
// Parameters:
//   WIN_SCORE : score that ends the match, 1..7
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   point1   : level request, player 1 scored
//   point2   : level request, player 2 scored
//   score1   : player 1 score
//   score2   : player 2 score
//   playing  : 1 while the match runs, 0 after a win
//   winner   : 0 = player 1 won, 1 = player 2 won (0 while playing)
// -----------------------------------------------------------------------------
module scores
  import scores_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               point1,
  input  logic               point2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               playing,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_Q = WIN_SCORE[SCORE_W-1:0];

  logic rise1_s;
  logic rise2_s;

  state_t             state_q,   state_d;
  logic [SCORE_W-1:0] score1_q,  score1_d;
  logic [SCORE_W-1:0] score2_q,  score2_d;
  logic               playing_q, playing_d;
  logic               winner_q,  winner_d;

  scores_edge_det u_edge1 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .point_i (point1),
    .rise_o  (rise1_s)
  );

  scores_edge_det u_edge2 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .point_i (point2),
    .rise_o  (rise2_s)
  );

  // Match FSM: score the lone rising edge, detect the win on the same edge.
  always_comb begin
    state_d   = state_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    playing_d = playing_q;
    winner_d  = winner_q;
    case (state_q)
      PLAY: begin
        if (rise1_s && !rise2_s) begin
          score1_d = score_inc(score1_q);
          if (score1_d == WIN_Q) begin
            state_d   = OVER;
            playing_d = 1'b0;
            winner_d  = P1_WIN;
          end else begin
            state_d   = PLAY;
          end
        end else if (rise2_s && !rise1_s) begin
          score2_d = score_inc(score2_q);
          if (score2_d == WIN_Q) begin
            state_d   = OVER;
            playing_d = 1'b0;
            winner_d  = P2_WIN;
          end else begin
            state_d   = PLAY;
          end
        end else begin
          // No edge, or both players at once: a tie event counts for nobody.
          state_d = PLAY;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        // Unreachable encoding: freeze the match rather than keep counting.
        state_d   = OVER;
        playing_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PLAY;
      score1_q  <= {SCORE_W{1'b0}};
      score2_q  <= {SCORE_W{1'b0}};
      playing_q <= 1'b1;
      winner_q  <= P1_WIN;
    end else begin
      state_q   <= state_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      playing_q <= playing_d;
      winner_q  <= winner_d;
    end
  end

  assign score1  = score1_q;
  assign score2  = score2_q;
  assign playing = playing_q;
  assign winner  = winner_q;

endmodule

// File: tb/tb_scores.sv
// -----------------------------------------------------------------------------
// tb_scores
// Self-checking bench for the score keeper. A reference model tracks the
// match from the point lines as seen LAT clocks late, and is compared against
// the DUT on every falling clock edge; directed steps also pin literal values.
// -----------------------------------------------------------------------------
module tb_scores;

  localparam int WIN = 5;
`ifdef SCORES_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       point1;
  logic       point2;
  logic [2:0] score1;
  logic [2:0] score2;
  logic       playing;
  logic       winner;

  int n_tests;
  int n_fail;

  scores #(.WIN_SCORE(WIN)) dut (
    .clk     (clk),
    .reset   (reset),
    .point1  (point1),
    .point2  (point2),
    .score1  (score1),
    .score2  (score2),
    .playing (playing),
    .winner  (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // h1/h2 hold the line values seen on past edges (bit 0 = last edge).
  bit [3:0] h1, h2;
  bit [4:0] v1, v2;
  int       m_s1, m_s2;
  bit       m_play, m_win;
  bit       r1, r2;

  assign v1 = {h1, point1};
  assign v2 = {h2, point2};
  // The model sees a line LAT edges late; a point is a 0->1 step in that view.
  assign r1 = v1[LAT] && !v1[LAT+1];
  assign r2 = v2[LAT] && !v2[LAT+1];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 <= 4'd0; h2 <= 4'd0;
      m_s1 <= 0; m_s2 <= 0; m_play <= 1'b1; m_win <= 1'b0;
    end else begin
      h1 <= {h1[2:0], point1};
      h2 <= {h2[2:0], point2};
      if (m_play && r1 && !r2) begin
        m_s1 <= m_s1 + 1;
        if (m_s1 + 1 == WIN) begin m_play <= 1'b0; m_win <= 1'b0; end
      end else if (m_play && r2 && !r1) begin
        m_s2 <= m_s2 + 1;
        if (m_s2 + 1 == WIN) begin m_play <= 1'b0; m_win <= 1'b1; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    n_tests = n_tests + 4;
    if (int'(score1) != m_s1) begin n_fail++; $display("FAIL model_score1 t=%0t got %0d expected %0d", $time, score1, m_s1); end
    if (int'(score2) != m_s2) begin n_fail++; $display("FAIL model_score2 t=%0t got %0d expected %0d", $time, score2, m_s2); end
    if (playing != m_play)    begin n_fail++; $display("FAIL model_playing t=%0t got %0d expected %0d", $time, playing, m_play); end
    if (playing == m_play && !m_play && winner != m_win) begin
      n_fail++; $display("FAIL model_winner t=%0t got %0d expected %0d", $time, winner, m_win);
    end else if (m_play && winner != 1'b0) begin
      n_fail++; $display("FAIL model_winner_idle t=%0t got %0d expected 0", $time, winner);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int s1, input int s2, input int pl, input int wn);
    check({name, "_score1"},  int'(score1),  s1);
    check({name, "_score2"},  int'(score2),  s2);
    check({name, "_playing"}, int'(playing), pl);
    check({name, "_winner"},  int'(winner),  wn);
  endtask

  task automatic do_reset();
    point1 = 1'b0; point2 = 1'b0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // One-clock-high, one-clock-low pulse, then wait out the input latency.
  task automatic pulse(input bit p1, input bit p2);
    point1 = p1; point2 = p2;
    tick();
    point1 = 1'b0; point2 = 1'b0;
    tick();
    repeat (LAT) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    point1 = 1'b0; point2 = 1'b0; reset = 1'b0;

    // Reset then idle.
    do_reset();
    repeat (10) tick();
    check_all("idle", 0, 0, 1, 0);

    // A long-held line counts once.
    point1 = 1'b1;
    repeat (20) tick();
    point1 = 1'b0;
    repeat (2 + LAT) tick();
    check_all("hold", 1, 0, 1, 0);

    // Player 1 wins with five pulses; further pulses are ignored.
    do_reset();
    for (int i = 1; i <= WIN; i++) begin
      pulse(1'b1, 1'b0);
      check($sformatf("p1_step%0d", i), int'(score1), i);
      check($sformatf("p1_play%0d", i), int'(playing), (i == WIN) ? 0 : 1);
    end
    check_all("p1_won", 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    check_all("p1_frozen", 5, 0, 0, 0);

    // Player 2 wins.
    do_reset();
    for (int i = 1; i <= WIN; i++) pulse(1'b0, 1'b1);
    check_all("p2_won", 0, 5, 0, 1);

    // Simultaneous edges count for nobody; a lone edge afterwards counts.
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check_all("tie", 1, 0, 1, 0);
    pulse(1'b1, 1'b0);
    check_all("after_tie", 2, 0, 1, 0);

    // Asynchronous reset mid-match, between clock edges.
    do_reset();
    repeat (3) pulse(1'b1, 1'b0);
    repeat (2) pulse(1'b0, 1'b1);
    check_all("pre_areset", 3, 2, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_all("areset", 0, 0, 1, 0);
    tick();
    reset = 1'b1;
    tick();

    // Line already high at reset release counts once, after LAT extra clocks.
    point1 = 1'b1; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("latency_first", int'(score1), (LAT == 0) ? 1 : 0);
    repeat (LAT) tick();
    check("latency_done", int'(score1), 1);
    repeat (5) tick();
    check("latency_hold", int'(score1), 1);
    point1 = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
